// File: rtl/cell_input_conditioner.sv
// rtl/cell_input_conditioner.sv - button synchroniser, debouncer and press arbiter for the nine grid cells
//
// Purpose:
//   Turns nine raw, bouncing push-buttons into at most one clean one-cycle
//   move strobe per physical press. Simultaneous presses, presses on an
//   occupied cell and presses after game over are turned into a reject pulse.
//   After any accepted or rejected press, all buttons must be released
//   before the next press is considered.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   btn_raw[8:0]  in   raw buttons, bit0 = cell a .. bit8 = cell i, 1 = pressed
//   cell_occupied in   per-cell occupied flags from the core, same bit order
//   game_over     in   game finished flag from the core
//   move[8:0]     out  one-hot, one-cycle press strobe to the core
//   move_strobe   out  OR of move
//   reject        out  one-cycle pulse when a debounced press is discarded
//   busy          out  high while waiting for every button to be released

module cell_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] btn_raw,
   input  logic [8:0] cell_occupied,
   input  logic       game_over,
   output logic [8:0] move,
   output logic       move_strobe,
   output logic       reject,
   output logic       busy
);

   typedef enum logic {IDLE, WAIT_REL} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [8:0]       sync1;
   logic [8:0]       sync2;
   logic [8:0]       stable;
   logic [8:0]       stable_q;
   logic [CNT_W-1:0] cnt [9];

   state_t     state;
   state_t     state_n;
   logic [8:0] move_n;
   logic       reject_n;
   logic [8:0] rise;
   logic       single_press;
   logic       blocked;

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Per-bit debounce: the counter only runs while the synchronised input
   // disagrees with the debounced value, and stable flips on the
   // DEBOUNCE_CYCLES-th consecutive disagreeing edge. Any agreeing edge
   // restarts the count, so short glitches never reach stable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 9; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable_q <= stable;
         for (int i = 0; i < 9; i++) begin
            if (sync2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // rise is valid for exactly the cycle after stable updates, so the
   // decision is registered one edge after the debounced press appears.
   assign rise = stable & ~stable_q;

   // A clean single press is one rising bit with no other button held.
   assign single_press = (rise != '0) && ((rise & (rise - 9'd1)) == '0) && (stable == rise);
   assign blocked      = game_over | (|(cell_occupied & rise));

   always_comb begin
      state_n  = state;
      move_n   = '0;
      reject_n = 1'b0;
      case (state)
         IDLE: begin
            if (rise != '0) begin
               state_n = WAIT_REL;
               if (single_press && !blocked) begin
                  move_n = rise;
               end else begin
                  reject_n = 1'b1;
               end
            end
         end
         WAIT_REL: begin
            if (stable == '0) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         move        <= '0;
         move_strobe <= 1'b0;
         reject      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         move        <= move_n;
         move_strobe <= |move_n;
         reject      <= reject_n;
         busy        <= (state_n == WAIT_REL);
      end
   end

endmodule
